// File: rtl/pipe_pkg.sv
// Shared definitions for the single-bit pipe stream blocks.
// The framer state encoding lives here so that receivers and framers agree on it.
package pipe_pkg;

    typedef enum logic {
        PIPE_HUNT   = 1'b0,
        PIPE_LOCKED = 1'b1
    } pipe_state_e;

    // Receivers wait for an explicit sync strobe unless told otherwise.
    localparam bit PIPE_SYNC_REQ_DEF = 1'b1;

endpackage

// File: rtl/pipe_deser.sv
// Serial-to-parallel receiver: assembles LN strobed bits LSB-first into a word and
// offers it on a valid/ready port. The serial side cannot stall, so drops are reported sticky.
module pipe_deser
    import pipe_pkg::*;
#(
    parameter int LN       = 8,
    parameter bit SYNC_REQ = PIPE_SYNC_REQ_DEF
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    input  logic          i_ce,
    input  logic          i_bit,
    input  logic          i_sync,
    output logic [LN-1:0] o_word,
    output logic          o_valid,
    input  logic          i_ready,
    output logic          o_locked,
    output logic          o_overrun,
    input  logic          i_clr_overrun
);

    localparam int              CW   = $clog2(LN);
    localparam logic [CW-1:0]   LAST = CW'(LN - 1);
    localparam logic [CW-1:0]   ONE  = CW'(1);

    pipe_state_e   state;
    logic [LN-1:0] sreg;
    logic [CW-1:0] cnt;
    logic [CW-1:0] eff;
    logic [LN-1:0] word_next;
    logic          accept;
    logic          complete;
    logic          drop;

    // A sync strobe forces the incoming bit to be bit 0, even while hunting.
    assign eff       = i_sync ? '0 : cnt;
    assign accept    = i_ce && ((state == PIPE_LOCKED) || i_sync);
    assign complete  = accept && (eff == LAST);
    assign word_next = {i_bit, sreg[LN-1:1]};
    assign drop      = complete && o_valid && !i_ready;
    assign o_locked  = (state == PIPE_LOCKED);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state <= SYNC_REQ ? PIPE_HUNT : PIPE_LOCKED;
            sreg  <= '0;
            cnt   <= '0;
        end else if (accept) begin
            state <= PIPE_LOCKED;
            sreg  <= word_next;
            cnt   <= (eff == LAST) ? '0 : eff + ONE;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_word  <= '0;
            o_valid <= 1'b0;
        end else if (complete && (!o_valid || i_ready)) begin
            o_word  <= word_next;
            o_valid <= 1'b1;
        end else if (!complete && o_valid && i_ready) begin
            o_valid <= 1'b0;
        end
    end

    // A drop in the same cycle as a clear keeps the flag set.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n)
            o_overrun <= 1'b0;
        else if (drop)
            o_overrun <= 1'b1;
        else if (i_clr_overrun)
            o_overrun <= 1'b0;
    end

`ifndef SYNTHESIS
    a_word_stable: assert property (@(posedge i_clk) disable iff (!i_reset_n)
        $past(o_valid && !i_ready) |-> $stable(o_word));

    a_cnt_range: assert property (@(posedge i_clk) disable iff (!i_reset_n)
        int'(cnt) < LN);

    a_overrun_sticky: assert property (@(posedge i_clk) disable iff (!i_reset_n)
        $fell(o_overrun) |-> $past(i_clr_overrun));
`endif

endmodule

// File: tb/tb_pipe_deser.sv
// Directed bench for pipe_deser (LN=8, sync required) with hand-computed expectations.
module tb_pipe_deser;

    localparam int LN = 8;

    logic          i_clk = 1'b0;
    logic          i_reset_n;
    logic          i_ce;
    logic          i_bit;
    logic          i_sync;
    logic [LN-1:0] o_word;
    logic          o_valid;
    logic          i_ready;
    logic          o_locked;
    logic          o_overrun;
    logic          i_clr_overrun;

    int n_chk  = 0;
    int n_fail = 0;

    pipe_deser #(.LN(LN), .SYNC_REQ(1'b1)) dut (
        .i_clk         (i_clk),
        .i_reset_n     (i_reset_n),
        .i_ce          (i_ce),
        .i_bit         (i_bit),
        .i_sync        (i_sync),
        .o_word        (o_word),
        .o_valid       (o_valid),
        .i_ready       (i_ready),
        .o_locked      (o_locked),
        .o_overrun     (o_overrun),
        .i_clr_overrun (i_clr_overrun)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs at the falling edge; return 1 time unit after the rising edge.
    task automatic step(input logic ce, input logic b, input logic sync);
        @(negedge i_clk);
        i_ce   = ce;
        i_bit  = b;
        i_sync = sync;
        @(posedge i_clk);
        #1;
    endtask

    // Send a word LSB-first; gap idle cycles follow each strobe except the last.
    task automatic send_word(input logic [7:0] w, input bit sync_first, input int gap,
                             input string tag);
        for (int i = 0; i < LN; i++) begin
            step(1'b1, w[i], sync_first && (i == 0));
            if (i == LN - 2) chk({tag, "_valid_early"}, 32'(o_valid), 32'(0));
            if (i < LN - 1)
                for (int g = 0; g < gap; g++) step(1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic do_reset();
        @(negedge i_clk);
        i_reset_n = 1'b0;
        @(posedge i_clk);
        @(negedge i_clk);
        i_reset_n = 1'b1;
    endtask

    initial begin
        i_reset_n     = 1'b0;
        i_ce          = 1'b0;
        i_bit         = 1'b0;
        i_sync        = 1'b0;
        i_ready       = 1'b1;
        i_clr_overrun = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        chk("rst_word",    32'(o_word),    32'h00);
        chk("rst_valid",   32'(o_valid),   32'(0));
        chk("rst_overrun", 32'(o_overrun), 32'(0));
        chk("rst_locked",  32'(o_locked),  32'(0));
        @(negedge i_clk);
        i_reset_n = 1'b1;

        // Basic synced word, consumer ready
        step(1'b1, 1'b1, 1'b1);
        chk("a5_lock_first_bit", 32'(o_locked), 32'(1));
        for (int i = 1; i < LN; i++) begin
            step(1'b1, 1'(8'hA5 >> i), 1'b0);
            if (i == LN - 2) chk("a5_valid_early", 32'(o_valid), 32'(0));
        end
        chk("a5_valid", 32'(o_valid), 32'(1));
        chk("a5_word",  32'(o_word),  32'hA5);
        step(1'b0, 1'b0, 1'b0);
        chk("a5_valid_pulse", 32'(o_valid), 32'(0));
        chk("a5_word_hold",   32'(o_word),  32'hA5);

        // HUNT discards unsynced bits
        do_reset();
        for (int i = 0; i < 2 * LN; i++) step(1'b1, 1'b1, 1'b0);
        chk("hunt_valid",  32'(o_valid),  32'(0));
        chk("hunt_locked", 32'(o_locked), 32'(0));
        step(1'b0, 1'b0, 1'b1);
        chk("hunt_sync_no_ce", 32'(o_locked), 32'(0));
        send_word(8'h3C, 1'b1, 0, "3c");
        chk("3c_valid", 32'(o_valid), 32'(1));
        chk("3c_word",  32'(o_word),  32'h3C);
        step(1'b0, 1'b0, 1'b0);

        // Back-pressure: second word dropped, sticky overrun
        i_ready = 1'b0;
        send_word(8'h11, 1'b1, 0, "11");
        chk("11_valid",   32'(o_valid),   32'(1));
        chk("11_word",    32'(o_word),    32'h11);
        chk("11_overrun", 32'(o_overrun), 32'(0));
        for (int i = 0; i < LN; i++) step(1'b1, 1'(8'h22 >> i), 1'b0);
        chk("22_drop_word",    32'(o_word),    32'h11);
        chk("22_drop_valid",   32'(o_valid),   32'(1));
        chk("22_drop_overrun", 32'(o_overrun), 32'(1));
        i_ready = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        chk("11_consumed",      32'(o_valid),   32'(0));
        chk("11_consumed_word", 32'(o_word),    32'h11);
        chk("overrun_sticky",   32'(o_overrun), 32'(1));
        i_clr_overrun = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        i_clr_overrun = 1'b0;
        chk("overrun_clr", 32'(o_overrun), 32'(0));

        // Sparse strobes
        send_word(8'h81, 1'b0, 2, "81");
        chk("81_valid", 32'(o_valid), 32'(1));
        chk("81_word",  32'(o_word),  32'h81);
        step(1'b0, 1'b0, 1'b0);

        // Mid-word resync discards the partial word
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0);
        chk("partial_valid", 32'(o_valid), 32'(0));
        send_word(8'h5A, 1'b1, 0, "5a");
        chk("5a_valid",   32'(o_valid),   32'(1));
        chk("5a_word",    32'(o_word),    32'h5A);
        chk("5a_overrun", 32'(o_overrun), 32'(0));
        step(1'b0, 1'b0, 1'b0);
        chk("5a_single", 32'(o_valid), 32'(0));

        // Async reset mid-word with a pending word and overrun set
        i_ready = 1'b0;
        send_word(8'h77, 1'b1, 0, "77");
        for (int i = 0; i < LN; i++) step(1'b1, 1'(8'h66 >> i), 1'b0);
        chk("pre_rst_valid",   32'(o_valid),   32'(1));
        chk("pre_rst_overrun", 32'(o_overrun), 32'(1));
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0);
        #2;
        i_reset_n = 1'b0;
        #1;
        chk("arst_word",    32'(o_word),    32'h00);
        chk("arst_valid",   32'(o_valid),   32'(0));
        chk("arst_overrun", 32'(o_overrun), 32'(0));
        chk("arst_locked",  32'(o_locked),  32'(0));
        @(posedge i_clk);
        @(negedge i_clk);
        i_reset_n = 1'b1;
        i_ready   = 1'b1;
        send_word(8'hFF, 1'b1, 0, "ff");
        chk("ff_valid",  32'(o_valid),  32'(1));
        chk("ff_word",   32'(o_word),   32'hFF);
        chk("ff_locked", 32'(o_locked), 32'(1));
        step(1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_deser.md
# pipe_deser

Serial-to-parallel receiver for the single-bit pipe stream: collects LN clock-enabled bits (first-received bit lands in bit 0, matching the LSB-first order in which a shift pipe emits them) into a word and presents it on a valid/ready output port. It sits at the far end of a serial bit pipe and hands complete words to parallel logic. Optional framing via a sync strobe. Sticky overrun reporting, because the serial side cannot be stalled.

## Interface
- LN, 8: word width in bits; legal range LN >= 2.
- SYNC_REQ, 1: 1 = ignore bits after reset until the first i_sync; 0 = start assembling immediately.

Ports:
- i_clk  in  1  clock; all logic on posedge.
- i_reset_n  in  1  asynchronous, active-low reset.
- i_ce  in  1  bit strobe; i_bit and i_sync are sampled only when high.
- i_bit  in  1  serial data bit.
- i_sync  in  1  with i_ce: this bit is bit 0 of a new word.
- o_word  out  LN  assembled word; bit 0 = earliest received bit.
- o_valid  out  1  o_word holds an unconsumed word.
- i_ready  in  1  consumer accepts o_word when o_valid && i_ready at a clock edge.
- o_locked  out  1  high in LOCKED state.
- o_overrun  out  1  sticky: a completed word was dropped.
- i_clr_overrun  in  1  clears o_overrun.

## Operation
- Shift register sreg[LN-1:0]: on i_ce, sreg <= {i_bit, sreg[LN-1:1]}.
- Bit counter cnt has width $clog2(LN) and counts 0..LN-1.
- Effective index is eff = i_sync ? 0 : cnt.
- Each accepted bit sets cnt <= (eff == LN-1) ? 0 : eff + 1.
- FSM states:
  - HUNT: bits are discarded; sreg and cnt are held. An i_ce && i_sync moves to LOCKED, and that bit is accepted as bit 0.
  - LOCKED: every i_ce bit is accepted. LOCKED is never left except by reset.
- Reset state: HUNT if SYNC_REQ=1, else LOCKED.
- Word completion: a bit is accepted in LOCKED with eff == LN-1. The word is {i_bit, sreg[LN-1:1]}.
- A mid-word i_sync discards the partial word silently (no overrun) and restarts at bit 0.
- Output register behaviour on completion:
  - !o_valid, or (o_valid && i_ready): o_word <= new word, o_valid <= 1.
  - o_valid && !i_ready: new word dropped, o_word unchanged, o_overrun <= 1.
  - No completion and o_valid && i_ready: o_valid <= 0; o_word holds its last value.
- o_overrun: a set and an i_clr_overrun in the same cycle leave o_overrun = 1 (set wins).
- o_word never changes while o_valid && !i_ready.

## Timing
- Reset values: sreg=0, cnt=0, o_word=0, o_valid=0, o_overrun=0, o_locked = !SYNC_REQ.
- Reset is asynchronous: it clears mid-word and mid-handshake immediately, and a pending word is lost.
- Latency: o_valid and o_word update at the same edge that samples the final bit, so they are visible one cycle after that bit is presented.
- Back-to-back: with i_ce held high, a word completes every LN cycles. o_valid may stay high continuously if i_ready is high at each completion edge.
- o_locked rises at the edge sampling the first i_ce && i_sync.
- i_ready is don't-care while !o_valid. i_sync without i_ce has no effect.

## Structure
- Shared package pipe_pkg holds:
  - FSM state encoding constants PIPE_HUNT and PIPE_LOCKED, shared with future pipe framers.
  - The sync-required default.
- Single module. Counter, shift register and output register are inline; no sub-module is warranted.
- Target 150-250 lines of RTL, including formal properties:
  - o_word stable while o_valid && !i_ready.
  - cnt < LN.
  - o_overrun never falls without i_clr_overrun or reset.

## Test plan
- LN=8, SYNC_REQ=1, i_ce high: send 0xA5 LSB-first with i_sync on the first bit, i_ready=1 -> o_valid pulses one cycle, o_word=8'hA5, o_locked=1 from the first bit.
- Bits sent before any i_sync in HUNT -> no o_valid. Then a synced 0x3C -> o_word=8'h3C.
- i_ready=0 for two consecutive words 0x11, 0x22 -> o_word stays 8'h11, o_overrun=1. Then i_ready=1 -> 0x11 consumed, o_valid=0. Then i_clr_overrun -> o_overrun=0.
- i_ce asserted every third cycle, word 0x81 -> same result as continuous: o_word=8'h81 at the edge of the 8th strobe.
- i_sync after 5 bits, then a full 0x5A -> no overrun, only 8'h5A delivered.
- Assert i_reset_n=0 mid-word and with o_valid=1 -> all outputs zero immediately, o_locked=0. The following synced word 0xFF is received correctly.
